// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared types and constants for the PLL supervisor.
//   state_e       - supervisor FSM state encoding
//   CNT_W         - width of the shared per-state cycle counter
//   *_DEF         - default timing parameters (25 MHz board clock)
//   last_count()  - terminal counter value for an N-cycle interval
package pll_sup_pkg;

  localparam int CNT_W             = 20;
  localparam int RST_CYCLES_DEF    = 16;
  localparam int LOCK_TIMEOUT_DEF  = 25000;
  localparam int STABLE_CYCLES_DEF = 256;

  typedef enum logic [1:0] {
    RESET_PLL   = 2'd0,
    WAIT_LOCK   = 2'd1,
    STABLE_WAIT = 2'd2,
    RUN         = 2'd3
  } state_e;

  // The counter starts at 0 on state entry, so an N-cycle interval ends at N-1.
  function automatic logic [CNT_W-1:0] last_count(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/pll_supervisor_sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit.
//   clk_25m - destination clock
//   rst     - synchronous active-high reset, clears both flops
//   d_i     - asynchronous input
//   q_o     - synchronized output (2 cycles latency)
module sync_2ff (
  input  logic clk_25m,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_supervisor.sv
// pll_supervisor: sequences PLL reset, waits for lock with timeout, qualifies
// lock stability and reports readiness.
//   clk_25m      - 25 MHz board clock, all logic on rising edge
//   rst          - synchronous active-high reset
//   pll_locked   - raw PLL LOCK (asynchronous)
//   pll_rst      - registered PLL reset request
//   pll_ready    - registered, high while lock is qualified
//   timeout_err  - registered one-cycle pulse per lock timeout
//   relock_count - saturating count of lock losses while ready
// Build option: define PLL_SUPERVISOR_STATS_EN to compile in relock_count;
// otherwise relock_count is tied to zero.
module pll_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = RST_CYCLES_DEF,
  parameter int LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic       clk_25m,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       pll_ready,
  output logic       timeout_err,
  output logic [7:0] relock_count
);

  localparam logic [CNT_W-1:0] RST_LAST    = last_count(RST_CYCLES);
  localparam logic [CNT_W-1:0] LOCK_LAST   = last_count(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] STABLE_LAST = last_count(STABLE_CYCLES);

  logic             lk_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pll_rst_q, pll_rst_d;
  logic             pll_ready_q, pll_ready_d;
  logic             timeout_q, timeout_d;

  sync_2ff u_sync (
    .clk_25m (clk_25m),
    .rst     (rst),
    .d_i     (pll_locked),
    .q_o     (lk_s)
  );

  // Next-state, counter and output decode; outputs follow the next state so
  // they are registered yet aligned with the state they describe.
  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
        end else begin
          state_d = RESET_PLL;
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (lk_s) begin
          state_d = STABLE_WAIT;
        end else if (cnt_q == LOCK_LAST) begin
          state_d   = RESET_PLL;
          timeout_d = 1'b1;
        end else begin
          state_d = WAIT_LOCK;
        end
      end
      STABLE_WAIT: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
        end else begin
          state_d = STABLE_WAIT;
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_d = RESET_PLL;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RESET_PLL;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    pll_rst_d   = (state_d == RESET_PLL);
    pll_ready_d = (state_d == RUN);
  end

  // State, counter and output registers.
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      state_q     <= RESET_PLL;
      cnt_q       <= {CNT_W{1'b0}};
      pll_rst_q   <= 1'b1;
      pll_ready_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_rst_q   <= pll_rst_d;
      pll_ready_q <= pll_ready_d;
      timeout_q   <= timeout_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign pll_ready   = pll_ready_q;
  assign timeout_err = timeout_q;

`ifdef PLL_SUPERVISOR_STATS_EN
  logic       lock_lost_s;
  logic [7:0] relock_q, relock_d;

  // Saturating relock counter increment on loss of lock while running.
  always_comb begin
    lock_lost_s = (state_q == RUN) && !lk_s;
    if (lock_lost_s && (relock_q != 8'd255)) begin
      relock_d = relock_q + 8'd1;
    end else begin
      relock_d = relock_q;
    end
  end

  // Relock counter register.
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      relock_q <= 8'd0;
    end else begin
      relock_q <= relock_d;
    end
  end

  assign relock_count = relock_q;
`else
  assign relock_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_supervisor.sv
// Table-driven bench for pll_supervisor with RST_CYCLES=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=8. Expected relock_count depends on PLL_SUPERVISOR_STATS_EN.
module tb_pll_supervisor;

  logic       clk_25m = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       pll_ready;
  logic       timeout_err;
  logic [7:0] relock_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic       lock;
    logic       e_rst;
    logic       e_rdy;
    logic       e_to;
    logic [7:0] e_rc;
  } vec_t;

  vec_t vecs[$];

  pll_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8)
  ) dut (
    .clk_25m      (clk_25m),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .pll_ready    (pll_ready),
    .timeout_err  (timeout_err),
    .relock_count (relock_count)
  );

  always #5 clk_25m = ~clk_25m;

  function automatic logic [7:0] rc_exp(input int n);
`ifdef PLL_SUPERVISOR_STATS_EN
    return (n > 255) ? 8'd255 : 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  // Expected values for cycle j after the initial reset (hand-derived timeline).
  function automatic vec_t make_vec(input int j);
    vec_t v;
    int   rcn;
    v.rst  = (j == 126);
    v.lock = (j >= 57 && j <= 75) || (j >= 79 && j <= 95) ||
             (j >= 97 && j <= 106) || (j >= 108);
    if (j <= 51) v.e_rst = ((j % 24) <= 3);
    else         v.e_rst = (j >= 78 && j <= 81) || (j >= 98 && j <= 101) ||
                           (j >= 126 && j <= 129);
    v.e_rdy = (j >= 67 && j <= 77) || (j >= 91 && j <= 97) ||
              (j >= 118 && j <= 125) || (j >= 139);
    v.e_to  = (j == 24) || (j == 48);
    rcn = (j < 78) ? 0 : (j < 98) ? 1 : (j < 126) ? 2 : 0;
    v.e_rc = rc_exp(rcn);
    return v;
  endfunction

  // One clock: drive, advance past the edge, check invariants.
  task automatic step(input logic r, input logic l, input logic no_to);
    rst = r;
    pll_locked = l;
    @(posedge clk_25m);
    #1;
    checks++;
    if (pll_rst && pll_ready) begin
      errors++;
      $display("FAIL excl: pll_rst=%b pll_ready=%b, required not both high", pll_rst, pll_ready);
    end
    if (no_to) begin
      checks++;
      if (timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL no_timeout: timeout_err=%b, required 0", timeout_err);
      end
    end
  endtask

  task automatic check_rc(input string name, input logic [7:0] exp);
    checks++;
    if (relock_count !== exp) begin
      errors++;
      $display("FAIL %s: relock_count=%0d, required %0d", name, relock_count, exp);
    end
  endtask

  initial begin
    vec_t v;
    int   cyc;

    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
    for (int j = 1; j <= 142; j++) vecs.push_back(make_vec(j));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      step(v.rst, v.lock, 1'b0);
      checks++;
      if ({pll_rst, pll_ready, timeout_err, relock_count} !== {v.e_rst, v.e_rdy, v.e_to, v.e_rc}) begin
        errors++;
        $display("FAIL vec%0d: rst/rdy/to/rc=%b/%b/%b/%0d, required %b/%b/%b/%0d",
                 i, pll_rst, pll_ready, timeout_err, relock_count,
                 v.e_rst, v.e_rdy, v.e_to, v.e_rc);
      end
    end

    // Repeated lock losses from RUN to exercise relock saturation.
    for (int n = 1; n <= 300; n++) begin
      step(1'b0, 1'b0, 1'b1);
      cyc = 0;
      while (pll_ready && cyc < 10) begin
        step(1'b0, 1'b1, 1'b1);
        cyc++;
      end
      checks++;
      if (pll_ready) begin
        errors++;
        $display("FAIL ready_drop loss%0d: pll_ready=1 after %0d cycles, required 0", n, cyc);
      end
      cyc = 0;
      while (!pll_ready && cyc < 60) begin
        step(1'b0, 1'b1, 1'b1);
        cyc++;
      end
      checks++;
      if (!pll_ready) begin
        errors++;
        $display("FAIL ready_return loss%0d: pll_ready=0 after %0d cycles, required 1", n, cyc);
      end
      if (n == 1 || n == 254 || n == 255 || n == 256 || n == 300)
        check_rc($sformatf("relock_n%0d", n), rc_exp(n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_supervisor.md
PLL_SUPERVISOR -- requirements
Module: pll_supervisor

Interface
REQ-001 Parameter RST_CYCLES, default 16: width of each pll_rst pulse, in clk_25m cycles; legal range 1 to 65535.
REQ-002 Parameter LOCK_TIMEOUT, default 25000: maximum cycles spent waiting for lock (1 ms at 25 MHz); legal range 1 to 2^20-1.
REQ-003 Parameter STABLE_CYCLES, default 256: consecutive locked cycles required before ready; legal range 1 to 65535.
REQ-004 clk_25m  input  1  free-running 25 MHz board clock, the only clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 pll_locked  input  1  raw PLL LOCK, asynchronous to clk_25m.
REQ-007 pll_rst  output  1  registered reset request driven to the PLL RST pin.
REQ-008 pll_ready  output  1  registered; high only while lock has been stable for STABLE_CYCLES.
REQ-009 timeout_err  output  1  registered single-cycle pulse on each lock timeout.
REQ-010 relock_count  output  8  number of lock losses seen while ready, saturating.

Function
REQ-011 pll_locked passes through a 2-flop synchronizer; all decisions use the synchronized value (lk), 2 cycles of latency.
REQ-012 FSM states: RESET_PLL, WAIT_LOCK, STABLE_WAIT, RUN; a single shared counter (20 bits) counts cycles in the current state and clears on every state change.
REQ-013 RESET_PLL: pll_rst=1; the FSM moves to WAIT_LOCK on the cycle the counter reaches RST_CYCLES-1, so pll_rst stays high for exactly RST_CYCLES cycles.
REQ-014 WAIT_LOCK: pll_rst=0.
  - lk=1: go to STABLE_WAIT.
  - Counter reaching LOCK_TIMEOUT-1 with lk=0: go to RESET_PLL and pulse timeout_err for one cycle.
REQ-015 STABLE_WAIT:
  - lk=0: return to WAIT_LOCK with the counter cleared; the timeout restarts.
  - Counter reaching STABLE_CYCLES-1 with lk=1: go to RUN.
REQ-016 RUN: pll_ready=1 (registered, asserted from the first RUN cycle). lk=0 drops pll_ready on that same edge, goes to RESET_PLL, and increments relock_count.
REQ-017 relock_count saturates at 255 and never wraps.
REQ-018 If timeout and lk=1 occur in the same WAIT_LOCK cycle, lock wins: go to STABLE_WAIT with no timeout_err pulse.
REQ-019 pll_ready and pll_rst are never high together.

Reset
REQ-020 When rst=1 at a clock edge:
  - state=RESET_PLL, counter=0, sync flops=0;
  - pll_rst=1, pll_ready=0, timeout_err=0, relock_count=0.
REQ-021 rst asserted in any state, including mid-pulse or in RUN, aborts that state; RESET_PLL then counts RST_CYCLES from the first cycle after rst is released.

Configuration
REQ-022 Macro PLL_SUPERVISOR_STATS_EN.
  - Defined: relock_count and its incrementer are compiled in as specified.
  - Undefined: no counter register exists and relock_count is tied to 8'd0.
  - FSM, pll_rst, pll_ready and timeout_err behave identically in both builds.

Structure
REQ-023 Package pll_sup_pkg holds:
  - the state enum type;
  - the counter width constant (20);
  - default constants for RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES.
REQ-024 The synchronizer is sub-module sync_2ff, 1-bit data, same clock and reset conventions; it has no other logic.

Verification (bench uses RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8)
REQ-025 Release rst with pll_locked=0 held -> pll_rst high for 4 cycles, low for 20, then timeout_err pulses once and pll_rst is high for 4 again; this repeats indefinitely with pll_ready=0.
REQ-026 Assert pll_locked 5 cycles after pll_rst falls and hold it -> pll_ready rises exactly 2+1+8 cycles after pll_locked rises and stays high; timeout_err is never pulsed.
REQ-027 In RUN, drop pll_locked for 3 cycles -> pll_ready falls 3 edges after the drop, pll_rst pulses 4 cycles, relock_count=1, and ready returns after relock.
REQ-028 In STABLE_WAIT after 5 locked cycles, glitch pll_locked low for 1 cycle -> pll_ready does not rise until 8 fresh consecutive locked cycles; no pll_rst pulse occurs.
REQ-029 With STATS_EN defined, force 300 lock losses in RUN -> relock_count holds at 255. Undefined: relock_count=0 throughout, and all other outputs match the defined build cycle-for-cycle.
REQ-030 Assert rst for 1 cycle while in RUN -> next edge pll_ready=0, pll_rst=1, relock_count=0; the sequence restarts as in REQ-025/026.
